swell_ng: RTL and testbench
===========================

Name: swell_ng

Overview:
Next-generation slow-gear / auto-swell volume shaper. It tracks a windowed mean-absolute envelope of the input and detects note attacks at window boundaries. On each attack it ramps a gain from its current value up to unity, then fades out on release rather than hard-muting. Audio passes through an internal look-ahead delay line so the ramp starts before the transient. The block sits in the per-sample effect chain, strobed by sample_tick_i.

Parameters:
DWIDTH, 16, sample width, two's complement
WIN_LOG2, 10, envelope window = 2**WIN_LOG2 samples
DELAY_AWIDTH, 10, look-ahead = 2**DELAY_AWIDTH samples
GAIN_W, 8, gain fraction bits; unity = 2**GAIN_W
STEP_W, 8, width of rise/fall step inputs

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous reset, active low
sample_tick_i  in  1  one-clock strobe per audio sample
enable_i  in  1  1 = effect active, 0 = bypass
threshold_i  in  DWIDTH-1  attack threshold on envelope rise
noise_floor_i  in  DWIDTH-1  release threshold
rise_step_i  in  STEP_W  gain increment per tick in ATTACK
fall_step_i  in  STEP_W  gain decrement per tick in RELEASE
data_i  in  DWIDTH  input sample, valid on tick
data_o  out  DWIDTH  output sample, registered
gain_o  out  GAIN_W+1  current gain
state_o  out  2  SILENCE=0, ATTACK=1, PASS=2, RELEASE=3

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk_i / arstn_i). While arstn_i=0: data_o=0, gain_o=0, state_o=SILENCE, envelopes, accumulator, window counter, write pointer and fill counter all 0. Delay RAM is not reset.
- Reset asserted mid-operation clears immediately, without waiting for a clock edge.
- All state advances only on sample_tick_i, except reset and the enable_i override.
- Magnitude: |data_i|, width DWIDTH-1. Most-negative input saturates to 2**(DWIDTH-1)-1.
- Envelope accumulator: width DWIDTH-1+WIN_LOG2, no overflow. It sums the magnitude every tick.
- On the last tick of a window: env_prev <= env, env <= (acc+mag)>>WIN_LOG2, and acc restarts at 0. The window end generates a one-clock window_done pulse.
- Attack detection is evaluated one clock after window_done only: env > env_prev + threshold_i, computed at DWIDTH bits, no wrap.
- Release detection is evaluated at the same point: env < noise_floor_i.
- Delay line: circular RAM of 2**DELAY_AWIDTH x DWIDTH, read-before-write at the write pointer, so the delay is exactly 2**DELAY_AWIDTH ticks. The pointer wraps naturally.
- Delay fill: a saturating fill counter forces the delayed sample to 0 until 2**DELAY_AWIDTH writes have occurred after reset.
- FSM:
  - SILENCE: gain=0. Attack -> ATTACK.
  - ATTACK: gain += rise_step_i per tick, saturating at unity. Reaching unity -> PASS on the same tick.
  - PASS: gain=unity. Release -> RELEASE. Attacks are ignored unless the optional feature is compiled in.
  - RELEASE: gain -= fall_step_i per tick, floored at 0. Reaching 0 -> SILENCE. Attack -> ATTACK, continuing from the current gain (no click).
- Step of 0: the FSM holds in ATTACK/RELEASE indefinitely (legal).
- Output: data_o <= (delayed * gain) >>> GAIN_W, signed, truncated toward -inf, registered on the clock after the tick (latency 1 clock). Unity gain gives bit-exact passthrough.
- enable_i=0: state forced to SILENCE, gain 0, envelope tracking continues. data_o <= data_i on each tick (1-clock registered bypass, no delay).
- enable_i 0->1: starts from SILENCE. The delay line keeps being written in bypass.

Optional Feature:
Macro: SWELL_RETRIGGER_EN.
- Defined: in PASS, an attack sets gain to unity>>2 and enters ATTACK, re-swelling each new note.
- Undefined: PASS ignores attacks; only release ends PASS.

Test Plan:
Bench setup: DWIDTH=16, WIN_LOG2=4, DELAY_AWIDTH=5, GAIN_W=8, STEP_W=8.
1. Bypass: enable_i=0, data_i=1234, tick -> data_o=1234 one clock later, state_o=0, gain_o=0.
2. Attack: threshold 100, 64 ticks of 0 then constant 1000, rise_step 16 -> ATTACK at the first window end. gain_o steps 16, 32 ... 256 over 16 ticks, then PASS. data_o=500 at gain 128, and 1000 in PASS, all 32 ticks after the input.
3. Release: from PASS with noise_floor 200, input drops to 50 -> RELEASE after the window. fall_step 32 gives 8 ticks to gain 0, then SILENCE; data_o=0 afterwards.
4. Full-scale negative: delayed -32768 with gain 128 -> data_o=-16384. Input -32768 gives envelope contribution 32767 (saturated magnitude).
5. Async reset: pull arstn_i low between clock edges mid-ATTACK -> data_o=0, gain_o=0, state_o=0 before the next edge. After release of reset, data_o stays 0 for 32 ticks (fill).
6. Retrigger (macro on): in PASS, a new 0->2000 jump exceeding the threshold -> gain_o=64, state_o=1, ramps back to 256. With the macro off: stays PASS, gain 256.

Source files
------------

// File: rtl/swell_ng.sv
// swell_ng: auto-swell volume shaper with a windowed envelope, look-ahead delay and gain ramp FSM.
// Optional SWELL_RETRIGGER_EN: an attack while in PASS restarts the swell from quarter gain.
module swell_ng #(
  parameter int DWIDTH       = 16,
  parameter int WIN_LOG2     = 10,
  parameter int DELAY_AWIDTH = 10,
  parameter int GAIN_W       = 8,
  parameter int STEP_W       = 8
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     sample_tick_i,
  input  logic                     enable_i,
  input  logic [DWIDTH-2:0]        threshold_i,
  input  logic [DWIDTH-2:0]        noise_floor_i,
  input  logic [STEP_W-1:0]        rise_step_i,
  input  logic [STEP_W-1:0]        fall_step_i,
  input  logic signed [DWIDTH-1:0] data_i,
  output logic signed [DWIDTH-1:0] data_o,
  output logic [GAIN_W:0]          gain_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {SILENCE = 2'd0, ATTACK = 2'd1, PASS = 2'd2, RELEASE = 2'd3} state_e;

  localparam int MW    = DWIDTH - 1;
  localparam int AW    = MW + WIN_LOG2;
  localparam int DEPTH = 1 << DELAY_AWIDTH;
  localparam int FW    = DELAY_AWIDTH + 1;
  localparam int GW1   = GAIN_W + 1;
  localparam int SW    = ((GW1 > STEP_W) ? GW1 : STEP_W) + 1;
  localparam int PW    = DWIDTH + GAIN_W + 2;
  localparam logic [GAIN_W:0] UNITY   = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [MW-1:0]   MAG_MAX = {MW{1'b1}};

  logic [MW-1:0]             mag_s;
  logic [AW-1:0]             acc_q, acc_sum_s;
  logic [WIN_LOG2-1:0]       win_cnt_q;
  logic [MW-1:0]             env_q, env_prev_q;
  logic                      win_done_q, att_pend_q, rel_pend_q;
  logic                      attack_s, release_s;
  logic signed [DWIDTH-1:0]  mem_q [DEPTH];
  logic [DELAY_AWIDTH-1:0]   wr_ptr_q;
  logic [FW-1:0]             fill_q;
  logic signed [DWIDTH-1:0]  delayed_s;
  state_e                    state_q, state_d;
  logic [GAIN_W:0]           gain_q, gain_d, fall_diff_s;
  logic [SW-1:0]             rise_sum_s;
  logic signed [PW-1:0]      dly_ext_s, gain_ext_s, prod_s;
  logic signed [DWIDTH-1:0]  data_q, data_d;
  logic                      unused_prod_s;

  // The most negative sample has no positive twin, so its magnitude saturates.
  always_comb begin
    if (data_i[DWIDTH-1]) begin
      if (data_i[MW-1:0] == '0) mag_s = MAG_MAX;
      else                      mag_s = ~data_i[MW-1:0] + MW'(1'b1);
    end else begin
      mag_s = data_i[MW-1:0];
    end
  end

  assign acc_sum_s = acc_q + AW'(mag_s);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      acc_q      <= '0;
      win_cnt_q  <= '0;
      env_q      <= '0;
      env_prev_q <= '0;
      win_done_q <= 1'b0;
    end else if (sample_tick_i) begin
      win_cnt_q <= win_cnt_q + WIN_LOG2'(1'b1);
      if (&win_cnt_q) begin
        env_prev_q <= env_q;
        env_q      <= acc_sum_s[AW-1:WIN_LOG2];
        acc_q      <= '0;
        win_done_q <= 1'b1;
      end else begin
        acc_q      <= acc_sum_s;
        win_done_q <= 1'b0;
      end
    end else begin
      win_done_q <= 1'b0;
    end
  end

  assign attack_s  = {1'b0, env_q} > ({1'b0, env_prev_q} + {1'b0, threshold_i});
  assign release_s = env_q < noise_floor_i;

  // Detections are latched after each window and consumed by the next sample tick.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      att_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
    end else if (win_done_q) begin
      att_pend_q <= attack_s;
      rel_pend_q <= release_s;
    end else if (sample_tick_i) begin
      att_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sample_tick_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (sample_tick_i) begin
      wr_ptr_q <= wr_ptr_q + DELAY_AWIDTH'(1'b1);
      if (!fill_q[DELAY_AWIDTH]) fill_q <= fill_q + FW'(1'b1);
    end
  end

  // Read-before-write: the slot about to be overwritten holds the sample from DEPTH ticks ago.
  always_comb begin
    if (fill_q[DELAY_AWIDTH]) delayed_s = mem_q[wr_ptr_q];
    else                      delayed_s = '0;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= SILENCE;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  assign rise_sum_s  = SW'(gain_q) + SW'(rise_step_i);
  assign fall_diff_s = gain_q - GW1'(fall_step_i);

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (!enable_i) begin
      state_d = SILENCE;
      gain_d  = '0;
    end else if (sample_tick_i) begin
      case (state_q)
        SILENCE: begin
          gain_d = '0;
          if (att_pend_q) state_d = ATTACK;
          else            state_d = SILENCE;
        end
        ATTACK: begin
          if (rise_sum_s >= SW'(UNITY)) begin
            gain_d  = UNITY;
            state_d = PASS;
          end else begin
            gain_d  = rise_sum_s[GAIN_W:0];
          end
        end
        PASS: begin
          gain_d = UNITY;
`ifdef SWELL_RETRIGGER_EN
          if (att_pend_q) begin
            gain_d  = UNITY >> 2;
            state_d = ATTACK;
          end else
`endif
          if (rel_pend_q) state_d = RELEASE;
          else            state_d = PASS;
        end
        RELEASE: begin
          if (att_pend_q) begin
            state_d = ATTACK;
          end else if (SW'(fall_step_i) >= SW'(gain_q)) begin
            gain_d  = '0;
            state_d = SILENCE;
          end else begin
            gain_d  = fall_diff_s;
          end
        end
        default: begin
          state_d = SILENCE;
          gain_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      gain_d  = gain_q;
    end
  end

  // Slicing the product is an arithmetic shift with truncation toward -inf.
  assign dly_ext_s     = PW'(delayed_s);
  assign gain_ext_s    = PW'($signed({1'b0, gain_q}));
  assign prod_s        = dly_ext_s * gain_ext_s;
  assign unused_prod_s = ^{prod_s[PW-1:GAIN_W+DWIDTH], prod_s[GAIN_W-1:0]};

  always_comb begin
    if (enable_i) data_d = prod_s[GAIN_W +: DWIDTH];
    else          data_d = data_i;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)           data_q <= '0;
    else if (sample_tick_i) data_q <= data_d;
  end

  assign data_o  = data_q;
  assign gain_o  = gain_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_swell_ng.sv
// Self-checking bench for swell_ng: bypass vector table, sample-level reference model with a
// scoreboard queue, and hand-checked swell / release / saturation / reset / retrigger sequences.
module tb_swell_ng;

  logic clk = 1'b0;
  logic arstn, tick, en;
  logic [14:0] thr, nf;
  logic [7:0]  rise, fall;
  logic signed [15:0] din;
  logic signed [15:0] dout;
  logic [8:0]  gain;
  logic [1:0]  st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  swell_ng #(.DWIDTH(16), .WIN_LOG2(4), .DELAY_AWIDTH(5), .GAIN_W(8), .STEP_W(8)) dut (
    .clk_i(clk), .arstn_i(arstn), .sample_tick_i(tick), .enable_i(en),
    .threshold_i(thr), .noise_floor_i(nf), .rise_step_i(rise), .fall_step_i(fall),
    .data_i(din), .data_o(dout), .gain_o(gain), .state_o(st)
  );

  typedef struct {int d; int g; int s;} exp_t;
  typedef struct {bit en; int din; int exp_d; int exp_g; int exp_s;} vec_t;
  exp_t sb_q[$];
  vec_t vecs[6];

  // reference model state (sample level)
  int m_state, m_gain, m_acc, m_cnt, m_env, m_envp, m_ptr, m_fill, m_dout;
  bit m_att, m_rel;
  int m_hist[32];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_gain = 0; m_acc = 0; m_cnt = 0; m_env = 0; m_envp = 0;
    m_ptr = 0; m_fill = 0; m_dout = 0; m_att = 0; m_rel = 0;
  endtask

  task automatic model_tick(input bit men, input int d);
    int dly, mag, nxt;
    bit a, r;
    dly = (m_fill == 32) ? m_hist[m_ptr] : 0;
    m_dout = men ? ((dly * m_gain) >>> 8) : d;
    a = m_att; r = m_rel; m_att = 0; m_rel = 0;
    if (!men) begin
      m_state = 0; m_gain = 0;
    end else begin
      case (m_state)
        0: if (a) m_state = 1;
        1: begin
          nxt = m_gain + int'(rise);
          if (nxt >= 256) begin m_gain = 256; m_state = 2; end
          else m_gain = nxt;
        end
        2: begin
`ifdef SWELL_RETRIGGER_EN
          if (a) begin m_gain = 64; m_state = 1; end else
`endif
          if (r) m_state = 3;
        end
        3: begin
          if (a) m_state = 1;
          else begin
            nxt = m_gain - int'(fall);
            if (nxt <= 0) begin m_gain = 0; m_state = 0; end
            else m_gain = nxt;
          end
        end
        default: m_state = 0;
      endcase
    end
    mag = (d < 0) ? ((d == -32768) ? 32767 : -d) : d;
    if (m_cnt == 15) begin
      m_envp = m_env;
      m_env  = (m_acc + mag) >> 4;
      m_acc  = 0;
      m_att  = (m_env > m_envp + int'(thr));
      m_rel  = (m_env < int'(nf));
    end else begin
      m_acc += mag;
    end
    m_cnt = (m_cnt + 1) % 16;
    m_hist[m_ptr] = d;
    m_ptr = (m_ptr + 1) % 32;
    if (m_fill < 32) m_fill++;
  endtask

  // one sample: model predicts, prediction queued, DUT ticked, result popped and compared
  task automatic do_tick(input int d);
    exp_t e;
    model_tick(en, d);
    e = '{m_dout, m_gain, m_state};
    sb_q.push_back(e);
    din  = 16'(d);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    e = sb_q.pop_front();
    chk("sb_data",  int'(dout), e.d);
    chk("sb_gain",  int'(gain), e.g);
    chk("sb_state", int'(st),   e.s);
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic run(input int d, input int n);
    for (int k = 0; k < n; k++) do_tick(d);
  endtask

  initial begin
    int saw_retrig;
    int exp_retrig;
    arstn = 1'b0; tick = 1'b0; en = 1'b0; din = 16'sd0;
    thr = 15'd100; nf = 15'd0; rise = 8'd16; fall = 8'd32;
    for (int i = 0; i < 32; i++) m_hist[i] = 0;
    model_reset();

    vecs[0] = '{1'b0, 1234,   1234,   0, 0};
    vecs[1] = '{1'b0, -1,     -1,     0, 0};
    vecs[2] = '{1'b0, -32768, -32768, 0, 0};
    vecs[3] = '{1'b0, 32767,  32767,  0, 0};
    vecs[4] = '{1'b0, 0,      0,      0, 0};
    vecs[5] = '{1'b0, 500,    500,    0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_data",  int'(dout), 0);
    chk("reset_gain",  int'(gain), 0);
    chk("reset_state", int'(st),   0);
    arstn = 1'b1;
    @(posedge clk); #1;

    // bypass table
    for (int i = 0; i < 6; i++) begin
      en = vecs[i].en;
      do_tick(vecs[i].din);
      chk("vec_data",  int'(dout), vecs[i].exp_d);
      chk("vec_gain",  int'(gain), vecs[i].exp_g);
      chk("vec_state", int'(st),   vecs[i].exp_s);
    end
    run(0, 40);

    // attack and ramp to PASS
    en = 1'b1;
    run(0, 64);
    chk("quiet_state", int'(st), 0);
    chk("quiet_gain",  int'(gain), 0);
    run(1000, 48);
    chk("pass_state", int'(st), 2);
    chk("pass_gain",  int'(gain), 256);
    chk("pass_data",  int'(dout), 1000);

    // release fades to silence
    nf = 15'd200;
    run(50, 60);
    chk("silence_state", int'(st), 0);
    chk("silence_gain",  int'(gain), 0);
    chk("silence_data",  int'(dout), 0);

    // hold half gain with zero rise step, then full-scale negative input
    nf = 15'd0; rise = 8'd0;
    for (int i = 0; i < 40 && m_state != 1; i++) do_tick(1000);
    chk("hold_attack_reached", int'(st), 1);
    rise = 8'd128;
    do_tick(1000);
    rise = 8'd0;
    run(1000, 40);
    chk("half_data",  int'(dout), 500);
    chk("half_gain",  int'(gain), 128);
    chk("half_state", int'(st),   1);
    run(-32768, 40);
    chk("negfs_data",  int'(dout), -16384);
    chk("negfs_state", int'(st),   1);
    nf = 15'd32767; rise = 8'd16;
    run(-32768, 40);
    chk("satmag_state", int'(st),   2);
    chk("satmag_gain",  int'(gain), 256);
    chk("satmag_data",  int'(dout), -32768);

    // retrigger from PASS
    nf = 15'd0;
    run(0, 32);
    chk("pre_retrig_state", int'(st), 2);
    saw_retrig = 0;
    for (int i = 0; i < 60; i++) begin
      do_tick(2000);
      if (st == 2'd1 && gain == 9'd64) saw_retrig = 1;
    end
`ifdef SWELL_RETRIGGER_EN
    exp_retrig = 1;
`else
    exp_retrig = 0;
`endif
    chk("retrig_seen",       saw_retrig, exp_retrig);
    chk("post_retrig_state", int'(st),   2);
    chk("post_retrig_gain",  int'(gain), 256);
    chk("post_retrig_data",  int'(dout), 2000);

    // back to silence, then async reset mid-ATTACK
    nf = 15'd32767; fall = 8'd255;
    run(0, 40);
    chk("fade_state", int'(st), 0);
    nf = 15'd0; rise = 8'd0;
    for (int i = 0; i < 40 && m_state != 1; i++) do_tick(2000);
    chk("rst_attack_reached", int'(st), 1);
    rise = 8'd128;
    do_tick(2000);
    rise = 8'd0;
    run(2000, 40);
    chk("pre_rst_data", int'(dout), 1000);
    #3 arstn = 1'b0;
    #1;
    chk("async_rst_data",  int'(dout), 0);
    chk("async_rst_gain",  int'(gain), 0);
    chk("async_rst_state", int'(st),   0);
    model_reset();
    sb_q.delete();
    @(posedge clk); #1;
    arstn = 1'b1;

    // delay fill masks stale RAM for the first 32 ticks
    thr = 15'd100; nf = 15'd0; rise = 8'd255; fall = 8'd32;
    for (int i = 0; i < 32; i++) begin
      do_tick(1000);
      chk("fill_zero", int'(dout), 0);
    end
    do_tick(1000);
    chk("fill_done", int'(dout), 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
